v2f_div_seq: RTL and testbench
==============================

Name: v2f_div_seq

Overview:
- Multi-cycle sequential divider producing quotient and remainder, i.e. the clocked counterpart of the combinational `v2f_div` / `v2f_mod` blackbox primitives.
- Sits in the same primitive library. The techmap flow uses it when a design marks a division as multi-cycle, so that a single-tick combinator divide is not forced on it.
- Uses shift/subtract restoring division, one quotient bit per clock, with valid/ready handshakes on both sides.

Parameters:
- `WIDTH`, default 32: operand, quotient and remainder width in bits. Legal range 2..32.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: dividend/divisor presented.
- `in_ready`, output, 1: block can accept an operation.
- `a`, input, WIDTH: dividend.
- `b`, input, WIDTH: divisor.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts result.
- `quot`, output, WIDTH: quotient.
- `rem`, output, WIDTH: remainder.
- `div_by_zero`, output, 1: result produced with `b == 0`.

Behaviour:
- The clock and reset are decided: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values while `rst_n` is low:
  - FSM state = IDLE.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `quot`, `rem` = 0.
  - `div_by_zero` = 0.
  - Internal iteration counter = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`, latch `a` and `b` and clear the partial remainder.
  - If `b == 0`, go to DONE. Otherwise go to BUSY with counter = WIDTH-1.
- BUSY:
  - `in_ready` = 0.
  - Each cycle: shift the partial remainder left by 1 and bring in the next dividend bit, MSB first.
  - If the partial remainder is >= divisor, subtract the divisor and shift a 1 into the quotient; otherwise shift in a 0.
  - When counter == 0, go to DONE; otherwise decrement the counter.
  - The partial remainder is WIDTH+1 bits wide internally so the compare cannot overflow.
- DONE:
  - `out_valid` = 1. `quot`, `rem` and `div_by_zero` are held stable until `out_ready` is sampled high.
  - When `out_ready` is high, go to IDLE at the next edge.
  - `in_ready` stays 0 in DONE. There is no result/accept overlap, so at most one operation is in flight.
- Latency:
  - For a normal divide, `out_valid` rises WIDTH+1 edges after the accepting edge (1 load edge + WIDTH iteration edges).
  - For divide-by-zero, `out_valid` rises on the edge after acceptance.
  - The minimum interval between accepts is WIDTH+2 cycles with `out_ready` tied high.
- Divide-by-zero result: `quot` = all ones, `rem` = `a`, `div_by_zero` = 1. This matches Verilog x/0 resolved to all ones, which is the team's decided value.
- `div_by_zero` is 0 for every nonzero divisor.
- Input changes on `a`, `b` or `in_valid` while in BUSY or DONE are ignored.
- Reset mid-operation (BUSY or DONE) aborts immediately: all outputs return to their reset values and the operation is lost.
- `out_ready` high while `out_valid` is low has no effect.
- Outputs come from registers only; there is no combinational path from inputs to outputs except `in_ready`, which is decoded from the state register.

Optional Feature:
- Macro: `V2F_DIV_SEQ_SIGNED_EN`.
- When defined:
  - An extra input `op_signed` (1 bit) exists, sampled at accept.
  - If `op_signed` = 1, operands are two's complement. Their magnitudes are divided by the unsigned core.
  - The quotient is negated when the operand signs differ. The remainder takes the sign of the dividend (truncation toward zero, as in Verilog `/` and `%`).
  - Sign fix-up is done in the DONE-entry edge, so latency is unchanged.
  - `-2^(WIDTH-1) / -1` gives `quot` = `-2^(WIDTH-1)` (wraps) and `rem` = 0.
  - Signed divide-by-zero gives `quot` = all ones and `rem` = `a`, the same as the unsigned case.
- When not defined: no `op_signed` port; all operands are unsigned.

Test Plan:
- WIDTH=8: a=200, b=7, out_ready=1 -> `out_valid` 9 edges after accept, quot=28, rem=4, `div_by_zero`=0.
- WIDTH=8: a=13, b=0 -> `out_valid` 1 edge after accept, quot=255, rem=13, `div_by_zero`=1.
- WIDTH=32: a=0xFFFFFFFF, b=1 -> quot=0xFFFFFFFF, rem=0. Then a=5, b=9 -> quot=0, rem=5.
- Backpressure: out_ready=0 for 20 cycles after `out_valid` -> outputs stable and `in_ready`=0 throughout. Raise out_ready -> IDLE next edge, `in_ready`=1.
- Reset: assert `rst_n` low 3 cycles into BUSY -> `out_valid`=0, quot=rem=0, `in_ready`=1 immediately. A new op (a=100, b=10) afterwards gives quot=10, rem=0.
- With `V2F_DIV_SEQ_SIGNED_EN`, WIDTH=8, op_signed=1:
  - a=-7, b=2 -> quot=-3, rem=-1.
  - a=-128, b=-1 -> quot=-128, rem=0.
  - Latency is still 9 edges.

Source files
------------

// File: rtl/v2f_div_seq_if.sv
// rtl/v2f_div_seq_if.sv - operand/result handshake bundle for v2f_div_seq
// op_signed exists only when V2F_DIV_SEQ_SIGNED_EN is defined.
`timescale 1ns/1ps
interface v2f_div_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_by_zero;
`ifdef V2F_DIV_SEQ_SIGNED_EN
  logic             op_signed;

  modport master (output in_valid, a, b, out_ready, op_signed,
                  input  in_ready, out_valid, quot, rem, div_by_zero);
  modport slave  (input  in_valid, a, b, out_ready, op_signed,
                  output in_ready, out_valid, quot, rem, div_by_zero);
`else
  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, quot, rem, div_by_zero);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, quot, rem, div_by_zero);
`endif
endinterface

// File: rtl/v2f_div_seq.sv
// rtl/v2f_div_seq.sv - multi-cycle restoring divider, one quotient bit per clock
// Optional signed operands via V2F_DIV_SEQ_SIGNED_EN.
`timescale 1ns/1ps
module v2f_div_seq #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  v2f_div_seq_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic             accept;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   prem_nxt;
  logic             qbit;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] r_raw;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign accept          = bus.in_valid && (state == IDLE);
  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dbz_q;

  // dvd doubles as the quotient register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_comb begin
    shifted  = {prem[WIDTH-1:0], dvd[WIDTH-1]};
    qbit     = (shifted >= {1'b0, dvs});
    prem_nxt = qbit ? (shifted - {1'b0, dvs}) : shifted;
    q_raw    = {dvd[WIDTH-2:0], qbit};
    r_raw    = prem_nxt[WIDTH-1:0];
  end

`ifdef V2F_DIV_SEQ_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic a_neg;
  logic b_neg;

  always_comb begin
    a_neg = bus.op_signed && bus.a[WIDTH-1];
    b_neg = bus.op_signed && bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
    q_fix = neg_q ? -q_raw : q_raw;
    r_fix = neg_r ? -r_raw : r_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
    q_fix = q_raw;
    r_fix = r_raw;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = (bus.b == '0) ? DONE : BUSY;
      BUSY: if (cnt == '0) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      prem   <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      if (accept) begin
        dvd  <= a_mag;
        dvs  <= b_mag;
        prem <= '0;
        cnt  <= CW'(WIDTH - 1);
        if (bus.b == '0) begin
          quot_q <= '1;
          rem_q  <= bus.a;
          dbz_q  <= 1'b1;
        end else begin
          dbz_q  <= 1'b0;
        end
      end else if (state == BUSY) begin
        prem <= prem_nxt;
        dvd  <= q_raw;
        if (cnt == '0) begin
          quot_q <= q_fix;
          rem_q  <= r_fix;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_v2f_div_seq.sv
// tb/tb_v2f_div_seq.sv - scoreboard bench for v2f_div_seq at WIDTH 8 and 32
// Signed vectors run only when V2F_DIV_SEQ_SIGNED_EN is defined.
`timescale 1ns/1ps
module tb_v2f_div_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  v2f_div_seq_if #(.WIDTH(8))  b8();
  v2f_div_seq_if #(.WIDTH(32)) b32();

  v2f_div_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  v2f_div_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        d;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[2][$];
  bit   seen[2];

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic mon(int i, logic ov, logic ordy, logic ir,
                     logic [31:0] q, logic [31:0] r, logic d);
    exp_t e;
    if (!ov) return;
    check($sformatf("in_ready_in_done[%0d]", i), 32'(ir), 32'd0);
    if (sb[i].size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_output[%0d]: got out_valid=1 required no result", i);
      return;
    end
    e = sb[i][0];
    if (!seen[i]) begin
      seen[i] = 1'b1;
      check($sformatf("latency[%0d]", i), 32'(cyc - e.acc + 1), 32'(e.lat));
    end
    check($sformatf("quot[%0d]", i), q, e.q);
    check($sformatf("rem[%0d]", i), r, e.r);
    check($sformatf("div_by_zero[%0d]", i), 32'(d), 32'(e.d));
    if (ordy) begin
      void'(sb[i].pop_front());
      seen[i] = 1'b0;
    end
  endtask

  always @(negedge clk)
    mon(0, b8.out_valid, b8.out_ready, b8.in_ready, 32'(b8.quot), 32'(b8.rem), b8.div_by_zero);
  always @(negedge clk)
    mon(1, b32.out_valid, b32.out_ready, b32.in_ready, b32.quot, b32.rem, b32.div_by_zero);

  task automatic issue(int i, logic [31:0] a, logic [31:0] b,
                       logic [31:0] q, logic [31:0] r, logic d, int lat);
    exp_t e;
    int   t = 0;
    @(negedge clk);
    while (((i == 0) ? b8.in_ready : b32.in_ready) !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_timeout[%0d]: got in_ready=0 required 1", i);
      return;
    end
    if (i == 0) begin
      b8.a = a[7:0]; b8.b = b[7:0]; b8.in_valid = 1'b1;
    end else begin
      b32.a = a; b32.b = b; b32.in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
    b32.in_valid = 1'b0;
    e.q = q; e.r = r; e.d = d; e.lat = lat; e.acc = cyc;
    sb[i].push_back(e);
  endtask

  task automatic wait_idle(int i);
    int t = 0;
    while (sb[i].size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout[%0d]: got %0d pending required 0", i, sb[i].size());
      sb[i].delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.a = '0; b32.b = '0; b32.out_ready = 1'b1;
`ifdef V2F_DIV_SEQ_SIGNED_EN
    b8.op_signed = 1'b0;
    b32.op_signed = 1'b0;
`endif
    #1;
    check("rst_in_ready", 32'(b8.in_ready), 32'd1);
    check("rst_out_valid", 32'(b8.out_valid), 32'd0);
    check("rst_quot", 32'(b8.quot), 32'd0);
    check("rst_rem", 32'(b8.rem), 32'd0);
    check("rst_dbz", 32'(b8.div_by_zero), 32'd0);
    check("rst_quot32", b32.quot, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(0, 200, 7, 28, 4, 0, 9);
    issue(0, 13, 0, 255, 13, 1, 1);
    issue(0, 255, 255, 1, 0, 0, 9);
    issue(0, 7, 200, 0, 7, 0, 9);
    issue(0, 255, 1, 255, 0, 0, 9);
    issue(0, 128, 3, 42, 2, 0, 9);
    issue(1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 0, 33);
    issue(1, 5, 9, 0, 5, 0, 33);
    issue(1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1);
    issue(1, 1000000, 7, 142857, 1, 0, 33);
    wait_idle(0);

    // Hold the result for 20 cycles, then release it.
    b8.out_ready = 1'b0;
    issue(0, 100, 7, 14, 2, 0, 9);
    t = 0;
    while (b8.out_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid_seen", 32'(b8.out_valid), 32'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp_out_valid_held", 32'(b8.out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    b8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", 32'(b8.in_ready), 32'd1);
    check("bp_release_out_valid", 32'(b8.out_valid), 32'd0);
    wait_idle(0);
    wait_idle(1);

    // Abort three cycles into BUSY; no result may appear.
    @(negedge clk);
    b8.a = 50; b8.b = 3; b8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(b8.out_valid), 32'd0);
    check("abort_quot", 32'(b8.quot), 32'd0);
    check("abort_rem", 32'(b8.rem), 32'd0);
    check("abort_in_ready", 32'(b8.in_ready), 32'd1);
    check("abort_dbz", 32'(b8.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 100, 10, 10, 0, 0, 9);

`ifdef V2F_DIV_SEQ_SIGNED_EN
    wait_idle(0);
    b8.op_signed = 1'b1;
    issue(0, 8'hF9, 2, 8'hFD, 8'hFF, 0, 9);
    issue(0, 8'h80, 8'hFF, 8'h80, 0, 0, 9);
    issue(0, 8'h07, 8'hFE, 8'hFD, 8'h01, 0, 9);
    issue(0, 8'hF9, 0, 8'hFF, 8'hF9, 1, 1);
    wait_idle(0);
    b8.op_signed = 1'b0;
`endif

    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
